// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: selects the next PC source, gates PC/IMEM, tracks
// fetch/decode validity and halt, and keeps saturating stall/redirect counters.
module fetch_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             jal_taken,
  input  logic             jalr_taken,
  input  logic             br_taken,
  input  logic             halt,
  output logic [1:0]       pc_sel,
  output logic             pc_en,
  output logic             imem_rden,
  output logic             fd_valid,
  output logic             flush_fd,
  output logic             flush_de,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redir_cnt
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_REDIR = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [1:0] SEL_NEXT = 2'b00;
  localparam logic [1:0] SEL_JALR = 2'b01;
  localparam logic [1:0] SEL_BR   = 2'b10;
  localparam logic [1:0] SEL_JAL  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic             fd_valid_q, fd_valid_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

  logic redir_acc;
  logic halt_acc;
  logic stall_acc;

  always_comb begin
    state_d   = state_q;
    pc_sel    = SEL_NEXT;
    pc_en     = 1'b0;
    imem_rden = 1'b0;
    flush_fd  = 1'b0;
    flush_de  = 1'b0;
    redir_acc = 1'b0;
    halt_acc  = 1'b0;
    stall_acc = 1'b0;

    case (state_q)
      ST_BOOT: begin
        pc_en     = 1'b1;
        imem_rden = 1'b1;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        // Execute-stage redirects win over HALT: the halting instruction is younger.
        if (br_taken) begin
          pc_sel    = SEL_BR;
          flush_de  = 1'b1;
          redir_acc = 1'b1;
        end else if (jalr_taken) begin
          pc_sel    = SEL_JALR;
          flush_de  = 1'b1;
          redir_acc = 1'b1;
        end else if (halt) begin
          halt_acc  = 1'b1;
          flush_fd  = 1'b1;
          state_d   = ST_HALT;
        end else if (jal_taken) begin
          pc_sel    = SEL_JAL;
          redir_acc = 1'b1;
        end else if (!stall) begin
          pc_en     = 1'b1;
          imem_rden = 1'b1;
        end
        if (redir_acc) begin
          pc_en     = 1'b1;
          imem_rden = 1'b1;
          flush_fd  = 1'b1;
          state_d   = ST_REDIR;
        end
        stall_acc = stall & ~redir_acc;
      end
      ST_REDIR: begin
        // Requests seen here come from squashed slots and are dropped.
        pc_en     = ~stall;
        imem_rden = ~stall;
        stall_acc = stall;
        state_d   = ST_RUN;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase

    if (!rst_n) begin
      pc_sel    = SEL_NEXT;
      pc_en     = 1'b0;
      imem_rden = 1'b0;
      flush_fd  = 1'b0;
      flush_de  = 1'b0;
    end
  end

  always_comb begin
    if (state_q == ST_HALT || redir_acc || halt_acc) begin
      fd_valid_d = 1'b0;
    end else if (imem_rden) begin
      fd_valid_d = 1'b1;
    end else begin
      fd_valid_d = fd_valid_q;
    end
    halted_d    = halted_q | halt_acc | (state_q == ST_HALT);
    stall_cnt_d = (stall_acc && stall_cnt_q != CNT_MAX) ? stall_cnt_q + CNT_ONE : stall_cnt_q;
    redir_cnt_d = (redir_acc && redir_cnt_q != CNT_MAX) ? redir_cnt_q + CNT_ONE : redir_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      fd_valid_q  <= 1'b0;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fd_valid_q  <= fd_valid_d;
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign fd_valid  = fd_valid_q;
  assign halted    = halted_q;
  assign stall_cnt = stall_cnt_q;
  assign redir_cnt = redir_cnt_q;

endmodule
